// File: rtl/e1_frame_aligner_if.sv
// Receive-side bus of the E1 frame aligner: serial line in, alignment flags and
// timeslot bytes out, plus the internal FSM states for observation.
interface e1_frame_aligner_if;
    // byte_valid is a one-cycle strobe with no ready: the consumer cannot stall,
    // and byte_out/ts are stable from the strobe until the next strobe.
    logic       din;
    logic       sync;
    logic       syncmulti;
    logic [7:0] bitcnt;
    logic [3:0] framecnt;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic [4:0] ts;
    logic [1:0] frame_state;
    logic       mf_state;

    modport master (
        input  din,
        output sync, syncmulti, bitcnt, framecnt, byte_out, byte_valid, ts,
        output frame_state, mf_state
    );

    modport slave (
        output din,
        input  sync, syncmulti, bitcnt, framecnt, byte_out, byte_valid, ts,
        input  frame_state, mf_state
    );
endinterface

// File: rtl/e1_frame_aligner.sv
// E1 (G.704) frame and CAS multiframe aligner: hunts for FAS, confirms it via
// NFAS/FAS, tracks loss, locks the TS16 multiframe and emits timeslot bytes.
module e1_frame_aligner (
    input  logic              clk,
    input  logic              reset,
    e1_frame_aligner_if.master bus
);
    localparam logic [1:0] HUNT     = 2'd0;
    localparam logic [1:0] CHK_NFAS = 2'd1;
    localparam logic [1:0] CHK_FAS  = 2'd2;
    localparam logic [1:0] SYNC     = 2'd3;
    localparam logic [0:0] MF_HUNT  = 1'b0;
    localparam logic [0:0] MF_SYNC  = 1'b1;
    localparam logic [6:0] FAS      = 7'b0011011;
    localparam logic [3:0] MFAS     = 4'b0000;

    logic [6:0] sr;
    logic [7:0] win;
    logic [1:0] state, state_n;
    logic [1:0] err, err_n;
    logic       fas_frame, fas_n;
    logic [7:0] bitcnt, bitcnt_n;
    logic [0:0] mf, mf_n;
    logic       mf_err, mf_err_n;
    logic       syncmulti, syncmulti_n;
    logic [3:0] framecnt, framecnt_n;
    logic       sync;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic [4:0] ts;
    logic       ts0_edge;
    logic       fas_match;
    logic       mfas_match;
    logic       byte_edge;

    assign win        = {sr, bus.din};
    assign ts0_edge   = (bitcnt == 8'd7);
    assign fas_match  = (win[6:0] == FAS);
    assign mfas_match = (win[7:4] == MFAS);

    always_comb begin
        state_n  = state;
        err_n    = err;
        fas_n    = fas_frame;
        bitcnt_n = bitcnt + 8'd1;
        case (state)
            HUNT: begin
                if (fas_match) begin
                    state_n  = CHK_NFAS;
                    bitcnt_n = 8'd8;
                end
            end
            CHK_NFAS: begin
                if (ts0_edge) state_n = win[6] ? CHK_FAS : HUNT;
            end
            CHK_FAS: begin
                if (ts0_edge) begin
                    if (fas_match) begin
                        state_n = SYNC;
                        fas_n   = 1'b1;
                        err_n   = 2'd0;
                    end else begin
                        state_n = HUNT;
                    end
                end
            end
            default: begin
                // fas_frame marks the frame just checked; only the alternate ones carry FAS.
                if (ts0_edge) begin
                    fas_n = ~fas_frame;
                    if (!fas_frame) begin
                        if (fas_match)        err_n   = 2'd0;
                        else if (err == 2'd2) state_n = HUNT;
                        else                  err_n   = err + 2'd1;
                    end
                end
            end
        endcase
        if (state_n == HUNT) bitcnt_n = 8'd0;
    end

    always_comb begin
        mf_n        = mf;
        mf_err_n    = mf_err;
        syncmulti_n = syncmulti;
        framecnt_n  = framecnt;
        if (state == SYNC && state_n == SYNC) begin
            if (mf == MF_HUNT) begin
                if (bitcnt == 8'd135 && mfas_match) begin
                    mf_n        = MF_SYNC;
                    mf_err_n    = 1'b0;
                    syncmulti_n = 1'b1;
                    framecnt_n  = 4'd0;
                end
            end else begin
                if (bitcnt == 8'd255) framecnt_n = framecnt + 4'd1;
                if (bitcnt == 8'd135 && framecnt == 4'd0) begin
                    if (mfas_match) begin
                        mf_err_n = 1'b0;
                    end else if (mf_err) begin
                        mf_n        = MF_HUNT;
                        mf_err_n    = 1'b0;
                        syncmulti_n = 1'b0;
                        framecnt_n  = 4'd0;
                    end else begin
                        mf_err_n = 1'b1;
                    end
                end
            end
        end else begin
            mf_n        = MF_HUNT;
            mf_err_n    = 1'b0;
            syncmulti_n = 1'b0;
            framecnt_n  = 4'd0;
        end
    end

    assign byte_edge = (bitcnt[2:0] == 3'd7) && (state_n == SYNC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr         <= 7'd0;
            state      <= HUNT;
            err        <= 2'd0;
            fas_frame  <= 1'b0;
            bitcnt     <= 8'd0;
            mf         <= MF_HUNT;
            mf_err     <= 1'b0;
            syncmulti  <= 1'b0;
            framecnt   <= 4'd0;
            sync       <= 1'b0;
            byte_out   <= 8'd0;
            byte_valid <= 1'b0;
            ts         <= 5'd0;
        end else begin
            sr         <= win[6:0];
            state      <= state_n;
            err        <= err_n;
            fas_frame  <= fas_n;
            bitcnt     <= bitcnt_n;
            mf         <= mf_n;
            mf_err     <= mf_err_n;
            syncmulti  <= syncmulti_n;
            framecnt   <= framecnt_n;
            sync       <= (state_n == SYNC);
            byte_valid <= byte_edge;
            if (byte_edge) begin
                byte_out <= win;
                ts       <= bitcnt[7:3];
            end
        end
    end

    assign bus.sync        = sync;
    assign bus.syncmulti   = syncmulti;
    assign bus.bitcnt      = bitcnt;
    assign bus.framecnt    = framecnt;
    assign bus.byte_out    = byte_out;
    assign bus.byte_valid  = byte_valid;
    assign bus.ts          = ts;
    assign bus.frame_state = state;
    assign bus.mf_state    = mf;
endmodule
